// File: rtl/spi_ifc.sv
// spi_ifc: SPI mode-0 slave front end, clocked entirely by SysClk.
// MOSI bytes are written into a receive memory at consecutive addresses.
// Bytes fetched from a transmit memory are shifted out MSB first on MISO.
// SPI pins are asynchronous and pass through 2-flop synchronizers.
// Optional build macro SPI_IFC_MISO_TRISTATE_EN: MISO floats (Z) whenever
// synced SS is high or Reset is low. Without it MISO is always driven.
module spi_ifc (
   input  logic        SysClk,
   input  logic        Reset,
   input  logic        SPI_CLK,
   input  logic        SPI_SS,
   input  logic        SPI_MOSI,
   output logic        SPI_MISO,
   output logic [11:0] txMemAddr,
   input  logic [7:0]  txMemData,
   output logic [11:0] rcMemAddr,
   output logic [7:0]  rcMemData,
   output logic        rcMemWE
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   state_t      state_q, state_d;

   logic [1:0]  sclk_sync_q, ss_sync_q, mosi_sync_q;
   logic        sclk_dly_q;
   logic [1:0]  prime_q;
   logic        ss_prev_q;

   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  rx_sh_q, rx_sh_d;
   logic [7:0]  tx_sh_q, tx_sh_d;
   logic [11:0] tx_addr_q, tx_addr_d;
   logic [11:0] rc_addr_q, rc_addr_d;
   logic [7:0]  rc_data_q, rc_data_d;
   logic        rc_we_q, rc_we_d;
   logic        byte_done_q, byte_done_d;
   logic        any_byte_q, any_byte_d;
   logic        miso_q, miso_d;

   logic        sclk_s, ss_s, mosi_s;
   logic        sclk_rise, sclk_fall, ss_start;

   // Synchronize the asynchronous SPI pins and keep the edge-detect history.
   // prime_q marks when ss_sync_q holds a real pin sample rather than its
   // reset value, so SS held low across reset release is not a start.
   always_ff @(posedge SysClk or negedge Reset) begin
      if (!Reset) begin
         sclk_sync_q <= 2'b00;
         ss_sync_q   <= 2'b11;
         mosi_sync_q <= 2'b00;
         sclk_dly_q  <= 1'b0;
         prime_q     <= 2'b00;
         ss_prev_q   <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[0], SPI_CLK};
         ss_sync_q   <= {ss_sync_q[0], SPI_SS};
         mosi_sync_q <= {mosi_sync_q[0], SPI_MOSI};
         sclk_dly_q  <= sclk_sync_q[1];
         prime_q     <= {prime_q[0], 1'b1};
         ss_prev_q   <= prime_q[1] & ss_sync_q[1];
      end
   end

   assign sclk_s    = sclk_sync_q[1];
   assign ss_s      = ss_sync_q[1];
   assign mosi_s    = mosi_sync_q[1];
   assign sclk_rise = sclk_s & ~sclk_dly_q;
   assign sclk_fall = ~sclk_s & sclk_dly_q;
   assign ss_start  = ss_prev_q & ~ss_s;

   // Next-state and datapath: transaction control, shifting and addressing.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_sh_d     = rx_sh_q;
      tx_sh_d     = tx_sh_q;
      tx_addr_d   = tx_addr_q;
      rc_addr_d   = rc_addr_q;
      rc_data_d   = rc_data_q;
      rc_we_d     = 1'b0;
      byte_done_d = 1'b0;
      any_byte_d  = any_byte_q;
      miso_d      = tx_sh_q[7];

      // A completed byte is always written, even if SS rises right after it.
      if (byte_done_q) begin
         rc_we_d   = 1'b1;
         rc_data_d = rx_sh_q;
      end
      if (rc_we_q) begin
         rc_addr_d = rc_addr_q + 12'd1;
      end

      case (state_q)
         ST_IDLE: begin
            bit_cnt_d  = 3'd0;
            rx_sh_d    = 8'h00;
            tx_addr_d  = 12'd0;
            tx_sh_d    = txMemData;
            any_byte_d = 1'b0;
            if (ss_start) begin
               state_d   = ST_ACTIVE;
               rc_addr_d = 12'd0;
               // byte 0 is already in tx_sh; prefetch byte 1
               tx_addr_d = 12'd1;
            end
         end
         ST_ACTIVE: begin
            if (ss_s) begin
               // partial byte is dropped
               state_d   = ST_IDLE;
               bit_cnt_d = 3'd0;
               rx_sh_d   = 8'h00;
               tx_addr_d = 12'd0;
            end else begin
               if (sclk_rise) begin
                  rx_sh_d   = {rx_sh_q[6:0], mosi_s};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     byte_done_d = 1'b1;
                     any_byte_d  = 1'b1;
                  end
               end
               if (sclk_fall) begin
                  if ((bit_cnt_q == 3'd0) && any_byte_q) begin
                     tx_sh_d   = txMemData;
                     tx_addr_d = tx_addr_q + 12'd1;
                  end else begin
                     tx_sh_d = {tx_sh_q[6:0], 1'b0};
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge SysClk or negedge Reset) begin
      if (!Reset) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 3'd0;
         rx_sh_q     <= 8'h00;
         tx_sh_q     <= 8'h00;
         tx_addr_q   <= 12'd0;
         rc_addr_q   <= 12'd0;
         rc_data_q   <= 8'h00;
         rc_we_q     <= 1'b0;
         byte_done_q <= 1'b0;
         any_byte_q  <= 1'b0;
         miso_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_sh_q     <= rx_sh_d;
         tx_sh_q     <= tx_sh_d;
         tx_addr_q   <= tx_addr_d;
         rc_addr_q   <= rc_addr_d;
         rc_data_q   <= rc_data_d;
         rc_we_q     <= rc_we_d;
         byte_done_q <= byte_done_d;
         any_byte_q  <= any_byte_d;
         miso_q      <= miso_d;
      end
   end

   assign txMemAddr = tx_addr_q;
   assign rcMemAddr = rc_addr_q;
   assign rcMemData = rc_data_q;
   assign rcMemWE   = rc_we_q;

`ifdef SPI_IFC_MISO_TRISTATE_EN
   assign SPI_MISO = (ss_s || !Reset) ? 1'bz : miso_q;
`else
   assign SPI_MISO = miso_q;
`endif

endmodule

// File: tb/tb_spi_ifc.sv
// tb_spi_ifc: directed self-checking bench for spi_ifc.
// SysClk is 40 ns. SPI pin edges are placed 2 ns past a SysClk edge and move
// in 5 ns steps, so they never coincide with a rising SysClk edge.
`timescale 1ns/1ps
module tb_spi_ifc;

   logic        SysClk   = 1'b0;
   logic        Reset    = 1'b0;
   logic        SPI_CLK  = 1'b0;
   logic        SPI_SS   = 1'b1;
   logic        SPI_MOSI = 1'b0;
   wire         SPI_MISO;
   logic [11:0] txMemAddr;
   logic [7:0]  txMemData = 8'h00;
   logic [11:0] rcMemAddr;
   logic [7:0]  rcMemData;
   logic        rcMemWE;

   logic [7:0]  txmem [0:4095];
   logic [11:0] wa [0:8191];
   logic [7:0]  wd [0:8191];
   int          wr_total = 0;
   int          tests_run = 0;
   int          tests_failed = 0;

   spi_ifc dut (
      .SysClk   (SysClk),
      .Reset    (Reset),
      .SPI_CLK  (SPI_CLK),
      .SPI_SS   (SPI_SS),
      .SPI_MOSI (SPI_MOSI),
      .SPI_MISO (SPI_MISO),
      .txMemAddr(txMemAddr),
      .txMemData(txMemData),
      .rcMemAddr(rcMemAddr),
      .rcMemData(rcMemData),
      .rcMemWE  (rcMemWE)
   );

   always #20 SysClk = ~SysClk;

   // transmit memory: data valid one SysClk after the address
   always @(posedge SysClk) txMemData <= txmem[txMemAddr];

   // receive memory write log
   always @(negedge SysClk) begin
      if (rcMemWE === 1'b1) begin
         wa[wr_total[12:0]] <= rcMemAddr;
         wd[wr_total[12:0]] <= rcMemData;
         wr_total <= wr_total + 1;
      end
   end

   task automatic align();
      @(posedge SysClk);
      #2;
   endtask

   task automatic spi_bit(input logic b, input int hi, input int lo, output logic s);
      SPI_MOSI = b;
      #(lo);
      s = SPI_MISO;
      SPI_CLK = 1'b1;
      #(hi);
      SPI_CLK = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] b, input int hi, input int lo, output logic [7:0] m);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(b[i], hi, lo, s);
         m[i] = s;
      end
   endtask

   task automatic ss_begin();
      SPI_SS = 1'b0;
      #200;
   endtask

   task automatic ss_end();
      #200;
      SPI_SS = 1'b1;
      #200;
   endtask

   task automatic test_reset();
      logic exp_miso;
`ifdef SPI_IFC_MISO_TRISTATE_EN
      exp_miso = 1'bz;
`else
      exp_miso = 1'b0;
`endif
      repeat (3) @(negedge SysClk);
      tests_run++;
      if (SPI_MISO !== exp_miso) begin
         tests_failed++; $display("FAIL reset_miso: got %b expected %b", SPI_MISO, exp_miso);
      end
      tests_run++;
      if (txMemAddr !== 12'd0) begin
         tests_failed++; $display("FAIL reset_txaddr: got %0d expected 0", txMemAddr);
      end
      tests_run++;
      if (rcMemAddr !== 12'd0) begin
         tests_failed++; $display("FAIL reset_rcaddr: got %0d expected 0", rcMemAddr);
      end
      tests_run++;
      if (rcMemData !== 8'h00) begin
         tests_failed++; $display("FAIL reset_rcdata: got %h expected 00", rcMemData);
      end
      tests_run++;
      if (rcMemWE !== 1'b0) begin
         tests_failed++; $display("FAIL reset_we: got %b expected 0", rcMemWE);
      end
      align();
      Reset = 1'b1;
      #200;
   endtask

   task automatic test_single();
      int base;
      logic [7:0] m;
      align();
      base = wr_total;
      ss_begin();
      spi_byte(8'hA5, 50, 50, m);
      ss_end();
      tests_run++;
      if (wr_total - base !== 1) begin
         tests_failed++; $display("FAIL single_count: got %0d writes expected 1", wr_total - base);
      end
      tests_run++;
      if (wa[base] !== 12'd0) begin
         tests_failed++; $display("FAIL single_addr: got %0d expected 0", wa[base]);
      end
      tests_run++;
      if (wd[base] !== 8'hA5) begin
         tests_failed++; $display("FAIL single_data: got %h expected a5", wd[base]);
      end
      tests_run++;
      if (rcMemAddr !== 12'd1) begin
         tests_failed++; $display("FAIL single_addr_after: got %0d expected 1", rcMemAddr);
      end
   endtask

   task automatic test_burst();
      int base;
      logic [7:0] m;
      logic [7:0] exp_d [4];
      exp_d = '{8'h01, 8'h02, 8'h03, 8'hFF};
      align();
      base = wr_total;
      ss_begin();
      for (int i = 0; i < 4; i++) spi_byte(exp_d[i], 50, 50, m);
      ss_end();
      tests_run++;
      if (wr_total - base !== 4) begin
         tests_failed++; $display("FAIL burst_count: got %0d writes expected 4", wr_total - base);
      end
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (wa[base+i] !== 12'(i)) begin
            tests_failed++; $display("FAIL burst_addr%0d: got %0d expected %0d", i, wa[base+i], i);
         end
         tests_run++;
         if (wd[base+i] !== exp_d[i]) begin
            tests_failed++; $display("FAIL burst_data%0d: got %h expected %h", i, wd[base+i], exp_d[i]);
         end
      end
   endtask

   task automatic test_transmit();
      logic [15:0] got;
      txmem[0] = 8'h3C;
      txmem[1] = 8'hC3;
      align();
      ss_begin();
      for (int i = 0; i < 16; i++) begin
         SPI_MOSI = 1'b0;
         #200;
         got[15-i] = SPI_MISO;
         SPI_CLK = 1'b1;
         #50;
         if (i == 7) begin
            tests_run++;
            if (txMemAddr !== 12'd1) begin
               tests_failed++; $display("FAIL tx_addr_mid: got %0d expected 1", txMemAddr);
            end
         end
         if (i == 15) begin
            tests_run++;
            if (txMemAddr !== 12'd2) begin
               tests_failed++; $display("FAIL tx_addr_end: got %0d expected 2", txMemAddr);
            end
         end
         SPI_CLK = 1'b0;
      end
      ss_end();
      tests_run++;
      if (got !== 16'h3CC3) begin
         tests_failed++; $display("FAIL tx_bits: got %h expected 3cc3", got);
      end
   endtask

   task automatic test_abort();
      int base;
      logic s;
      logic [7:0] m;
      align();
      base = wr_total;
      ss_begin();
      for (int i = 0; i < 5; i++) spi_bit(1'b1, 50, 50, s);
      ss_end();
      tests_run++;
      if (wr_total - base !== 0) begin
         tests_failed++; $display("FAIL abort_partial: got %0d writes expected 0", wr_total - base);
      end
      ss_begin();
      spi_byte(8'h5A, 50, 50, m);
      ss_end();
      tests_run++;
      if (wr_total - base !== 1) begin
         tests_failed++; $display("FAIL abort_count: got %0d writes expected 1", wr_total - base);
      end
      tests_run++;
      if (wa[base] !== 12'd0) begin
         tests_failed++; $display("FAIL abort_addr: got %0d expected 0", wa[base]);
      end
      tests_run++;
      if (wd[base] !== 8'h5A) begin
         tests_failed++; $display("FAIL abort_data: got %h expected 5a", wd[base]);
      end
   endtask

   task automatic test_reset_mid();
      int base;
      logic s;
      logic [7:0] m;
      logic exp_miso;
`ifdef SPI_IFC_MISO_TRISTATE_EN
      exp_miso = 1'bz;
`else
      exp_miso = 1'b0;
`endif
      align();
      base = wr_total;
      ss_begin();
      spi_bit(1'b0, 50, 50, s);
      spi_bit(1'b1, 50, 50, s);
      SPI_MOSI = 1'b1;
      #50;
      SPI_CLK = 1'b1;
      #20;
      Reset = 1'b0;
      @(negedge SysClk);
      tests_run++;
      if (SPI_MISO !== exp_miso) begin
         tests_failed++; $display("FAIL rmid_miso: got %b expected %b", SPI_MISO, exp_miso);
      end
      tests_run++;
      if (txMemAddr !== 12'd0) begin
         tests_failed++; $display("FAIL rmid_txaddr: got %0d expected 0", txMemAddr);
      end
      tests_run++;
      if (rcMemAddr !== 12'd0) begin
         tests_failed++; $display("FAIL rmid_rcaddr: got %0d expected 0", rcMemAddr);
      end
      tests_run++;
      if (rcMemData !== 8'h00) begin
         tests_failed++; $display("FAIL rmid_rcdata: got %h expected 00", rcMemData);
      end
      tests_run++;
      if (rcMemWE !== 1'b0) begin
         tests_failed++; $display("FAIL rmid_we: got %b expected 0", rcMemWE);
      end
      SPI_CLK = 1'b0;
      SPI_SS  = 1'b1;
      #100;
      align();
      Reset = 1'b1;
      #200;
      ss_begin();
      spi_byte(8'h77, 50, 50, m);
      ss_end();
      tests_run++;
      if (wr_total - base !== 1) begin
         tests_failed++; $display("FAIL rmid_count: got %0d writes expected 1", wr_total - base);
      end
      tests_run++;
      if (wa[base] !== 12'd0) begin
         tests_failed++; $display("FAIL rmid_addr: got %0d expected 0", wa[base]);
      end
      tests_run++;
      if (wd[base] !== 8'h77) begin
         tests_failed++; $display("FAIL rmid_data: got %h expected 77", wd[base]);
      end
   endtask

   task automatic test_wrap();
      int base;
      logic [7:0] m;
      align();
      base = wr_total;
      ss_begin();
      for (int i = 0; i <= 4096; i++) begin
         spi_byte(8'(i * 7 + 3), 45, 45, m);
         if (i == 4094) begin
            // 4095 bytes done, the following fall fetched byte 4095: address 4096 wraps to 0
            #200;
            tests_run++;
            if (txMemAddr !== 12'd0) begin
               tests_failed++; $display("FAIL wrap_txaddr: got %0d expected 0", txMemAddr);
            end
         end
      end
      ss_end();
      tests_run++;
      if (wr_total - base !== 4097) begin
         tests_failed++; $display("FAIL wrap_count: got %0d writes expected 4097", wr_total - base);
      end
      // byte 4095: data (4095*7+3) mod 256 = 0xFC
      tests_run++;
      if (wa[base+4095] !== 12'd4095) begin
         tests_failed++; $display("FAIL wrap_addr4095: got %0d expected 4095", wa[base+4095]);
      end
      tests_run++;
      if (wd[base+4095] !== 8'hFC) begin
         tests_failed++; $display("FAIL wrap_data4095: got %h expected fc", wd[base+4095]);
      end
      // byte 4096: data (4096*7+3) mod 256 = 0x03, address wraps to 0
      tests_run++;
      if (wa[base+4096] !== 12'd0) begin
         tests_failed++; $display("FAIL wrap_addr4096: got %0d expected 0", wa[base+4096]);
      end
      tests_run++;
      if (wd[base+4096] !== 8'h03) begin
         tests_failed++; $display("FAIL wrap_data4096: got %h expected 03", wd[base+4096]);
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) txmem[i] = 8'h00;
      test_reset();
      test_single();
      test_burst();
      test_transmit();
      test_abort();
      test_reset_mid();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
